// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the FIFO read port, the reader and its downstream consumer.
// With FIFO_READER_PARITY_EN defined the bundle also carries the per-word parity bit.
interface fifo_stream_reader_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) ();

  logic                 ARES_design_Enable;
  logic                 ARES_design_Empty;
  logic [WIDTH-1:0]     ARES_design_RData;
  logic                 ARES_design_Read;
  logic                 ARES_design_OValid;
  logic [WIDTH-1:0]     ARES_design_OData;
  logic                 ARES_design_OLast;
  logic                 ARES_design_OReady;
  logic                 ARES_design_Busy;
  logic [CNT_WIDTH-1:0] ARES_design_WordCount;
`ifdef FIFO_READER_PARITY_EN
  logic                 ARES_design_OParity;
`endif

  // The reader owns the pop strobe and the whole downstream stream.
  modport master (
    input  ARES_design_Enable,
    input  ARES_design_Empty,
    input  ARES_design_RData,
    input  ARES_design_OReady,
    output ARES_design_Read,
    output ARES_design_OValid,
    output ARES_design_OData,
    output ARES_design_OLast,
    output ARES_design_Busy,
`ifdef FIFO_READER_PARITY_EN
    output ARES_design_OParity,
`endif
    output ARES_design_WordCount
  );

  modport slave (
    output ARES_design_Enable,
    output ARES_design_Empty,
    output ARES_design_RData,
    output ARES_design_OReady,
    input  ARES_design_Read,
    input  ARES_design_OValid,
    input  ARES_design_OData,
    input  ARES_design_OLast,
    input  ARES_design_Busy,
`ifdef FIFO_READER_PARITY_EN
    input  ARES_design_OParity,
`endif
    input  ARES_design_WordCount
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO read-side controller: pops words into a 2-entry skid buffer and streams them as fixed-length bursts.
// Optional macro FIFO_READER_PARITY_EN adds a registered even-parity bit stored alongside each word.
module fifo_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic                  ARES_design_CLK,
  input logic                  ARES_design_RESET,
  fifo_stream_reader_if.master io_bus
);

  localparam logic [15:0] LAST_POS = 16'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [1:0]           r_occ;
  logic [1:0]           w_occNext;
  logic [WIDTH-1:0]     r_data0;
  logic [WIDTH-1:0]     r_data1;
  logic                 r_last0;
  logic                 r_last1;
  logic [15:0]          r_burstCnt;
  logic [15:0]          w_burstInc;
  logic [15:0]          w_tagPos;
  logic                 w_tagLast;
  logic [CNT_WIDTH-1:0] r_wordCount;
  logic                 w_pop;
  logic                 w_take;
`ifdef FIFO_READER_PARITY_EN
  logic                 r_par0;
  logic                 r_par1;
`endif

  // Pop depends only on registered occupancy, never on downstream ready.
  assign w_pop  = ~ARES_design_RESET & io_bus.ARES_design_Enable &
                  ~io_bus.ARES_design_Empty & (r_occ != 2'd2);
  assign w_take = (r_occ != 2'd0) & io_bus.ARES_design_OReady;

  assign w_burstInc = (r_burstCnt == LAST_POS) ? 16'd0 : r_burstCnt + 16'd1;
  // Head sits at r_burstCnt, so a word captured behind it is one position later.
  assign w_tagPos   = (r_occ == 2'd0) ? r_burstCnt : w_burstInc;
  assign w_tagLast  = (w_tagPos == LAST_POS);

  always_comb begin
    w_occNext = r_occ;
    if (w_pop && !w_take) begin
      w_occNext = r_occ + 2'd1;
    end else if (!w_pop && w_take) begin
      w_occNext = r_occ - 2'd1;
    end
  end

  always_ff @(posedge ARES_design_CLK) begin
    if (ARES_design_RESET) begin
      r_occ   <= 2'd0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
`ifdef FIFO_READER_PARITY_EN
      r_par0  <= 1'b0;
      r_par1  <= 1'b0;
`endif
    end else begin
      r_occ <= w_occNext;
      case (r_occ)
        2'd0: begin
          if (w_pop) begin
            r_data0 <= io_bus.ARES_design_RData;
            r_last0 <= w_tagLast;
`ifdef FIFO_READER_PARITY_EN
            r_par0  <= ^io_bus.ARES_design_RData;
`endif
          end
        end
        2'd1: begin
          // Simultaneous take and pop lets the new word replace the head directly.
          if (w_pop && w_take) begin
            r_data0 <= io_bus.ARES_design_RData;
            r_last0 <= w_tagLast;
`ifdef FIFO_READER_PARITY_EN
            r_par0  <= ^io_bus.ARES_design_RData;
`endif
          end else if (w_pop) begin
            r_data1 <= io_bus.ARES_design_RData;
            r_last1 <= w_tagLast;
`ifdef FIFO_READER_PARITY_EN
            r_par1  <= ^io_bus.ARES_design_RData;
`endif
          end
        end
        2'd2: begin
          if (w_take) begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
`ifdef FIFO_READER_PARITY_EN
            r_par0  <= r_par1;
`endif
          end
        end
        default: begin
          r_occ <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge ARES_design_CLK) begin
    if (ARES_design_RESET) begin
      r_burstCnt  <= 16'd0;
      r_wordCount <= '0;
    end else if (w_take) begin
      r_burstCnt  <= w_burstInc;
      r_wordCount <= r_wordCount + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge ARES_design_CLK) begin
    if (ARES_design_RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_pop) w_stateNext = RUN;
      end
      RUN: begin
        if (w_occNext == 2'd0) w_stateNext = IDLE;
        else if (!io_bus.ARES_design_Enable) w_stateNext = DRAIN;
      end
      DRAIN: begin
        if (w_pop) w_stateNext = RUN;
        else if (w_occNext == 2'd0) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign io_bus.ARES_design_Read      = w_pop;
  assign io_bus.ARES_design_OValid    = (r_occ != 2'd0);
  assign io_bus.ARES_design_OData     = r_data0;
  assign io_bus.ARES_design_OLast     = r_last0;
  assign io_bus.ARES_design_Busy      = (r_state != IDLE);
  assign io_bus.ARES_design_WordCount = r_wordCount;
`ifdef FIFO_READER_PARITY_EN
  assign io_bus.ARES_design_OParity   = r_par0;
`endif

endmodule
